// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipelined CPU: next-PC select codes,
// the NOP encoding, opcode constants and the fetch FSM state type.
package cpu_pkg;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_LR  = 2'b11;

    localparam logic [7:0] NOP_INSN = 8'h00;

    localparam logic [3:0] OP_ADD     = 4'h1;
    localparam logic [3:0] OP_LOAD    = 4'hD;
    localparam logic [3:0] OP_LOADIMM = 4'hF;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fetch_state_t;

    // Both redirect codes have bit 0 set; 2'b10 is reserved and falls through to sequential.
    function automatic logic is_redirect(input logic [1:0] sel);
        return (sel == PC_SEL_BR) || (sel == PC_SEL_LR);
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational PC+1 increment and 3-way next-PC target select.
module next_pc_sel
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        pc_sec,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] lr_target,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic [ADDR_W-1:0] next_pc,
    output logic              redirect
);

    assign pc_plus1 = pc + ADDR_W'(1);
    assign redirect = is_redirect(pc_sec);

    always_comb begin
        next_pc = pc_plus1;
        case (pc_sec)
            PC_SEL_BR: next_pc = br_target;
            PC_SEL_LR: next_pc = lr_target;
            default:   next_pc = pc_plus1;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem, fills the IF/ID register.
// Optional FETCH_STALL_CNT_EN adds the stall_cnt cycle counter output.
//
//   state | meaning
//   BOOT  | first cycle after reset, PC and IF/ID held, inputs ignored
//   RUN   | normal fetch, advance or redirect every cycle
//   STALL | pc_en low, PC and IF/ID held, stall_ctr counting
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                INSN_W    = 8,
    parameter logic [INSN_W-1:0] NOP_INSN  = INSN_W'(cpu_pkg::NOP_INSN),
    parameter int                MAX_STALL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_en,
    input  logic [1:0]        pc_sec,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] lr_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INSN_W-1:0] imem_rdata,
    output logic [INSN_W-1:0] id_insn,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_plus1,
    output logic              id_valid,
    output logic              stall_err
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int                CTR_W   = $clog2(MAX_STALL + 2);
    localparam logic [CTR_W-1:0] CTR_SAT = CTR_W'(MAX_STALL + 1);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] next_pc;
    logic              redirect;
    logic [CTR_W-1:0]  stall_ctr;
    logic [CTR_W-1:0]  ctr_inc;

    assign imem_addr = pc;
    assign ctr_inc   = (stall_ctr == CTR_SAT) ? stall_ctr : stall_ctr + CTR_W'(1);

    next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
        .pc        (pc),
        .pc_sec    (pc_sec),
        .br_target (br_target),
        .lr_target (lr_target),
        .pc_plus1  (pc_plus1),
        .next_pc   (next_pc),
        .redirect  (redirect)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= '0;
            id_insn     <= NOP_INSN;
            id_pc       <= '0;
            id_pc_plus1 <= '0;
            id_valid    <= 1'b0;
            stall_err   <= 1'b0;
            stall_ctr   <= '0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN, STALL: begin
                    if (redirect) begin
                        // The slot fetched this cycle is wrong-path; replace it with a bubble.
                        pc        <= next_pc;
                        id_insn   <= NOP_INSN;
                        id_valid  <= 1'b0;
                        stall_ctr <= '0;
                        state     <= RUN;
                    end else if (!pc_en) begin
                        stall_ctr <= ctr_inc;
                        if (ctr_inc == CTR_SAT)
                            stall_err <= 1'b1;
                        state <= STALL;
                    end else begin
                        pc          <= pc_plus1;
                        id_insn     <= imem_rdata;
                        id_pc       <= pc;
                        id_pc_plus1 <= pc_plus1;
                        id_valid    <= 1'b1;
                        stall_ctr   <= '0;
                        state       <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (state != BOOT && !redirect && !pc_en && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then random traffic
// compared against a cycle-level behavioural model.
module tb_fetch_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       pc_en;
    logic [1:0] pc_sec;
    logic [7:0] br_target;
    logic [7:0] lr_target;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic [7:0] id_insn;
    logic [7:0] id_pc;
    logic [7:0] id_pc_plus1;
    logic       id_valid;
    logic       stall_err;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    logic [7:0] mem [256];
    assign imem_rdata = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pc_en       (pc_en),
        .pc_sec      (pc_sec),
        .br_target   (br_target),
        .lr_target   (lr_target),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .id_insn     (id_insn),
        .id_pc       (id_pc),
        .id_pc_plus1 (id_pc_plus1),
        .id_valid    (id_valid),
        .stall_err   (stall_err)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: plain integers, updated from the fetch rules directly.
    int m_pc, m_insn, m_idpc, m_idpc1, m_valid, m_err, m_run_len, m_cnt;
    bit m_booting;

    task automatic model_step(input bit r, input bit en, input int sec, input int br, input int lr);
        if (r) begin
            m_pc = 0; m_insn = 0; m_idpc = 0; m_idpc1 = 0; m_valid = 0;
            m_err = 0; m_run_len = 0; m_cnt = 0; m_booting = 1;
        end else if (m_booting) begin
            m_booting = 0;
        end else if (sec == 1 || sec == 3) begin
            m_pc = (sec == 1) ? br : lr;
            m_insn = 0;
            m_valid = 0;
            m_run_len = 0;
        end else if (!en) begin
            if (m_run_len < 5) m_run_len++;
            if (m_run_len >= 5) m_err = 1;
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_insn  = mem[m_pc];
            m_idpc  = m_pc;
            m_idpc1 = (m_pc + 1) % 256;
            m_pc    = (m_pc + 1) % 256;
            m_valid = 1;
            m_run_len = 0;
        end
    endtask

    task automatic cyc(input bit r, input bit en, input int sec, input int br, input int lr);
        rst = r; pc_en = en; pc_sec = 2'(sec); br_target = 8'(br); lr_target = 8'(lr);
        model_step(r, en, sec, br, lr);
        @(posedge clk);
        #1;
        check("imem_addr", imem_addr, m_pc);
        check("id_insn", id_insn, m_insn);
        check("id_pc", id_pc, m_idpc);
        check("id_pc_plus1", id_pc_plus1, m_idpc1);
        check("id_valid", id_valid, m_valid);
        check("stall_err", stall_err, m_err);
`ifdef FETCH_STALL_CNT_EN
        check("stall_cnt", stall_cnt, m_cnt);
`endif
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 8'(k + 8'h10);
        rst = 1'b1; pc_en = 1'b0; pc_sec = 2'b00; br_target = '0; lr_target = '0;
        m_booting = 1;

        // Reset then sequential run
        cyc(1, 1, 0, 0, 0);
        check("rst_valid", id_valid, 0);
        check("rst_insn", id_insn, 8'h00);
        cyc(0, 1, 2, 8'h99, 8'h99);            // BOOT ignores everything
        check("boot_addr", imem_addr, 0);
        check("boot_valid", id_valid, 0);
        cyc(0, 1, 0, 0, 0);
        check("first_insn", id_insn, 8'h10);
        check("first_pc", id_pc, 0);
        check("first_valid", id_valid, 1);
        check("seq_addr1", imem_addr, 1);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
        check("at_pc5", imem_addr, 5);

        // Two-cycle stall at PC=5
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0, 0);
            check("stall_addr", imem_addr, 5);
            check("stall_insn", id_insn, 8'h14);
        end
        cyc(0, 1, 0, 0, 0);
        check("resume_addr", imem_addr, 6);
        check("resume_err", stall_err, 0);

        // Branch at PC=7
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 8'h40, 0);
        check("br_addr", imem_addr, 8'h40);
        check("br_flush_insn", id_insn, 8'h00);
        check("br_flush_valid", id_valid, 0);
        cyc(0, 1, 0, 0, 0);
        check("br_idpc", id_pc, 8'h40);

        // Wrap at 0xFF then link-register return
        cyc(0, 1, 1, 8'hFF, 0);
        cyc(0, 1, 0, 0, 0);
        check("wrap_addr", imem_addr, 8'h00);
        check("wrap_pc1", id_pc_plus1, 8'h00);
        cyc(0, 1, 3, 0, 8'h22);
        check("lr_addr", imem_addr, 8'h22);
        check("lr_flush", id_valid, 0);

        // Redirect beats stall while stalled
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 8'h30, 0);
        check("stall_redirect_addr", imem_addr, 8'h30);
        cyc(0, 1, 0, 0, 0);
        check("after_redirect_run", imem_addr, 8'h31);

        // Five consecutive stalls raise sticky stall_err
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 0, 0, 0);
            check("stall_err_ramp", stall_err, (i == 5) ? 1 : 0);
        end
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 8'h50, 0);
        check("err_sticky", stall_err, 1);

        // Reset in the middle of a stall
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("midrst_addr", imem_addr, 0);
        check("midrst_valid", id_valid, 0);
        check("midrst_err", stall_err, 0);
`ifdef FETCH_STALL_CNT_EN
        check("midrst_cnt", stall_cnt, 0);
`endif
        cyc(0, 1, 1, 8'h77, 0);               // BOOT again: redirect ignored
        check("midrst_boot", imem_addr, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, en;
            int sec;
            r   = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 2) != 0);
            sec = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : 0;
            cyc(r, en, sec, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 8-bit pipelined CPU; sits directly upstream of decode, the bubble/hazard check and branch control.
- Owns the PC and drives the instruction-memory address.
- Captures the fetched instruction into the IF/ID pipeline register.
- Applies stall (from bubble control) and redirect (pc_sec from branch control) with a fixed priority.
- Tracks stall length through a small FSM.

Parameters:
- ADDR_W, 8, PC and instruction-memory address width.
- INSN_W, 8, instruction width (op [7:4], ra [3:2], rb [1:0]).
- NOP_INSN, 8'h00, instruction injected on flush and reset.
- MAX_STALL, 4, largest legal number of consecutive stall cycles before stall_err is raised.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, synchronous, active-high reset.
- pc_en, input, 1, 1 = advance; 0 = stall PC and IF/ID (from bubble control).
- pc_sec, input, 2, next-PC select: 00 = PC+1; 01 = br_target; 11 = lr_target; 10 = reserved, treated as 00.
- br_target, input, ADDR_W, branch target address.
- lr_target, input, ADDR_W, link-register return address.
- imem_addr, output, ADDR_W, instruction-memory address; always equals PC.
- imem_rdata, input, INSN_W, instruction-memory read data; combinational from imem_addr.
- id_insn, output, INSN_W, IF/ID instruction.
- id_pc, output, ADDR_W, address of id_insn.
- id_pc_plus1, output, ADDR_W, id_pc+1 (link value for BR.SUB).
- id_valid, output, 1, id_insn is a real fetched instruction.
- stall_err, output, 1, sticky flag: stall exceeded MAX_STALL.

Behaviour:
- Reset (rst=1 at a clock edge): pc=0, id_insn=NOP_INSN, id_pc=0, id_pc_plus1=0, id_valid=0, stall_err=0, stall_ctr=0, FSM enters BOOT.
  - Reset overrides every other input.
  - Reset mid-stall or mid-redirect discards all state.
- FSM states: BOOT, RUN, STALL.
  - BOOT: one cycle only. PC holds 0, IF/ID holds NOP/invalid, pc_en and pc_sec are ignored. Next state is RUN.
  - RUN, redirect (pc_sec in {01,11}):
    - pc <= selected target.
    - IF/ID <= NOP_INSN, id_valid=0 (flushes the wrong-path fetch).
    - Stays in RUN.
  - RUN, pc_en=1 with no redirect:
    - pc <= pc+1, with 8-bit wrap (8'hFF -> 8'h00).
    - id_insn <= imem_rdata; id_pc <= pc; id_pc_plus1 <= pc+1; id_valid <= 1.
  - RUN, pc_en=0 with no redirect: PC and IF/ID hold; stall_ctr <= 1; go to STALL.
  - STALL, pc_en=0: hold; stall_ctr increments, saturating at MAX_STALL+1. stall_err <= 1 when stall_ctr reaches MAX_STALL+1.
  - STALL, pc_en=1: behave as RUN advance this cycle; stall_ctr <= 0; go to RUN.
- Priority: rst > redirect > stall > advance. A redirect during a stall takes effect immediately, flushes IF/ID and returns to RUN.
- Latency: instruction at PC=n appears on id_insn one cycle after imem_addr=n, provided there is no stall or redirect.
- stall_err clears only on rst.
- Outputs are registered except imem_addr, which is pc wired directly.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- Defined:
  - Extra output stall_cnt[15:0]: a free-running count of cycles with pc_en=0 while in RUN or STALL.
  - Saturates at 16'hFFFF; reset to 0.
  - Redirect cycles are not counted.
- Undefined: the port and the counter logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - PC_SEL_SEQ=2'b00, PC_SEL_BR=2'b01, PC_SEL_LR=2'b11.
  - NOP_INSN.
  - Opcode constants (ADD=1 … LOAD=D, LOADIMM=F).
  - Fetch FSM state enum {BOOT, RUN, STALL}.
- One sub-module, next_pc_sel: combinational PC+1 increment and 3-way target select.

Test Plan:
- Reset then run: imem word at addr k = k+8'h10, pc_en=1, pc_sec=00.
  - Required: cycle after BOOT imem_addr=0; next cycle id_insn=8'h10, id_pc=0, id_valid=1.
  - Required: addresses then run 1, 2, 3 …
- Stall 2 cycles at PC=5.
  - Required: imem_addr stays 5 and id_insn stays the word from addr 4 for 2 cycles.
  - Required: resumes with PC=6 next; stall_err=0.
- Branch at PC=7 with pc_sec=01, br_target=8'h40.
  - Required: next cycle imem_addr=8'h40, id_insn=8'h00, id_valid=0.
  - Required: following cycle id_pc=8'h40.
- Wrap and return: PC=8'hFF advancing gives imem_addr=8'h00, id_pc_plus1=8'h00.
  - Required: pc_sec=11 with lr_target=8'h22 gives imem_addr=8'h22 and a flushed slot.
- Simultaneous pc_en=0 and pc_sec=01 during STALL.
  - Required: redirect wins, PC = br_target, FSM returns to RUN.
  - Required: 5 consecutive stalls with MAX_STALL=4 give stall_err=1, held until rst.
- Reset asserted mid-stall (stall_ctr=3).
  - Required: next cycle pc=0, id_valid=0, stall_err=0, FSM in BOOT.
  - Required: with FETCH_STALL_CNT_EN defined, stall_cnt=0.
